// File: rtl/fft_pkg.sv
// Shared FFT datapath types and sizing for the CBFP stage-0 reorder buffer.
package fft_pkg;

  localparam int unsigned DATA_WIDTH = 13;
  localparam int unsigned LANES      = 16;
  localparam int unsigned BEATS      = 4;
  localparam int unsigned BEAT_W     = $clog2(BEATS);
  localparam int unsigned LANE_W     = $clog2(LANES);

  typedef logic signed [DATA_WIDTH-1:0] sample_t;
  typedef sample_t [0:LANES-1] lane_vec_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_e;

endpackage

// File: rtl/cbfp0_reorder_bank.sv
// One BEATS x LANES complex register bank: row-wise write port and a
// combinational transposed read port selecting column rd_col.
module cbfp0_reorder_bank
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [BEAT_W-1:0] wr_row,
  input  lane_vec_t         wr_real,
  input  lane_vec_t         wr_imag,
  input  logic [BEAT_W-1:0] rd_col,
  output lane_vec_t         rd_real_c,
  output lane_vec_t         rd_imag_c
);

  lane_vec_t   real_q [BEATS];
  lane_vec_t   imag_q [BEATS];
  lane_vec_t   real_d [BEATS];
  lane_vec_t   imag_d [BEATS];
  int unsigned idx;

  always_comb begin
    real_d = real_q;
    imag_d = imag_q;
    if (we) begin
      real_d[wr_row] = wr_real;
      imag_d[wr_row] = wr_imag;
    end
  end

  // Storage is deliberately not reset; the control path tracks validity.
  always_ff @(posedge clk) begin
    real_q <= real_d;
    imag_q <= imag_d;
  end

  // Output lane l of column k holds stored sample index BEATS*l + k.
  always_comb begin
    rd_real_c = '0;
    rd_imag_c = '0;
    idx       = 0;
    for (int unsigned l = 0; l < LANES; l++) begin
      idx = BEATS * l + 32'(rd_col);
      rd_real_c[LANE_W'(l)] = real_q[BEAT_W'(idx / LANES)][LANE_W'(idx % LANES)];
      rd_imag_c[LANE_W'(l)] = imag_q[BEAT_W'(idx / LANES)][LANE_W'(idx % LANES)];
    end
  end

endmodule

// File: rtl/cbfp0_reorder_buf.sv
// Ping-pong reorder buffer: collects 4x16-sample blocks from the stage-0
// CBFP normaliser and re-emits them transposed (stride-4) for step-1.
module cbfp0_reorder_buf
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              din_valid,
  input  logic              flush,
  input  lane_vec_t         bfly02_real,
  input  lane_vec_t         bfly02_imag,
  output logic              valid_out,
  output logic              frame_start,
  output logic [BEAT_W-1:0] beat_idx,
  output lane_vec_t         dout_real,
  output lane_vec_t         dout_imag
);

  logic [BEAT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic              wr_bank_q, wr_bank_d;
  rd_state_e         state_q, state_d;
  logic [BEAT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic              rd_bank_q, rd_bank_d;
  logic              valid_q, valid_d;
  logic              frame_start_q, frame_start_d;
  logic [BEAT_W-1:0] beat_idx_q, beat_idx_d;
  lane_vec_t         dout_real_q, dout_real_d;
  lane_vec_t         dout_imag_q, dout_imag_d;

  logic              wr_fire_c;
  logic              rd_req_c;
  logic              reading_c;
  lane_vec_t         bank_real_c [2];
  lane_vec_t         bank_imag_c [2];

  for (genvar g = 0; g < 2; g++) begin : g_bank
    cbfp0_reorder_bank u_bank (
      .clk       (clk),
      .we        (wr_fire_c && (wr_bank_q == 1'(g))),
      .wr_row    (wr_cnt_q),
      .wr_real   (bfly02_real),
      .wr_imag   (bfly02_imag),
      .rd_col    (rd_cnt_q),
      .rd_real_c (bank_real_c[g]),
      .rd_imag_c (bank_imag_c[g])
    );
  end

  // Write side: a flush cycle swallows any beat presented with it.
  always_comb begin
    wr_fire_c = din_valid && !flush;
    rd_req_c  = wr_fire_c && (wr_cnt_q == BEAT_W'(BEATS - 1));
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    if (flush) begin
      wr_cnt_d = '0;
    end else if (wr_fire_c) begin
      wr_cnt_d = rd_req_c ? '0 : wr_cnt_q + BEAT_W'(1);
      if (rd_req_c) wr_bank_d = !wr_bank_q;
    end
  end

  // Read FSM; a request on the final read beat chains with no bubble.
  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    rd_bank_d = rd_bank_q;
    case (state_q)
      RD_IDLE: begin
        if (rd_req_c) begin
          state_d   = RD_READ;
          rd_cnt_d  = '0;
          rd_bank_d = wr_bank_q;
        end
      end
      RD_READ: begin
        if (rd_cnt_q == BEAT_W'(BEATS - 1)) begin
          rd_cnt_d = '0;
          if (rd_req_c) begin
            rd_bank_d = wr_bank_q;
          end else begin
            state_d = RD_IDLE;
          end
        end else begin
          rd_cnt_d = rd_cnt_q + BEAT_W'(1);
        end
      end
      default: state_d = RD_IDLE;
    endcase
    if (flush) begin
      state_d  = RD_IDLE;
      rd_cnt_d = '0;
    end
  end

  always_comb begin
    reading_c     = (state_q == RD_READ) && !flush;
    valid_d       = reading_c;
    frame_start_d = reading_c && (rd_cnt_q == '0);
    beat_idx_d    = reading_c ? rd_cnt_q : '0;
    dout_real_d   = '0;
    dout_imag_d   = '0;
    if (reading_c) begin
      dout_real_d = bank_real_c[rd_bank_q];
      dout_imag_d = bank_imag_c[rd_bank_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_q      <= '0;
      wr_bank_q     <= 1'b0;
      state_q       <= RD_IDLE;
      rd_cnt_q      <= '0;
      rd_bank_q     <= 1'b0;
      valid_q       <= 1'b0;
      frame_start_q <= 1'b0;
      beat_idx_q    <= '0;
      dout_real_q   <= '0;
      dout_imag_q   <= '0;
    end else begin
      wr_cnt_q      <= wr_cnt_d;
      wr_bank_q     <= wr_bank_d;
      state_q       <= state_d;
      rd_cnt_q      <= rd_cnt_d;
      rd_bank_q     <= rd_bank_d;
      valid_q       <= valid_d;
      frame_start_q <= frame_start_d;
      beat_idx_q    <= beat_idx_d;
      dout_real_q   <= dout_real_d;
      dout_imag_q   <= dout_imag_d;
    end
  end

  // A new block may only complete while idle or on the last read beat.
  always @(posedge clk) begin
    if (!rst && rd_req_c && (state_q == RD_READ))
      assert (rd_cnt_q == BEAT_W'(BEATS - 1));
  end

  assign valid_out   = valid_q;
  assign frame_start = frame_start_q;
  assign beat_idx    = beat_idx_q;
  assign dout_real   = dout_real_q;
  assign dout_imag   = dout_imag_q;

endmodule

// File: tb/tb_cbfp0_reorder_buf.sv
// Directed bench for cbfp0_reorder_buf: cycle table plus reset and
// full-range corner sequences.
module tb_cbfp0_reorder_buf;
  import fft_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              din_valid;
  logic              flush;
  lane_vec_t         in_re;
  lane_vec_t         in_im;
  logic              valid_out;
  logic              frame_start;
  logic [BEAT_W-1:0] beat_idx;
  lane_vec_t         dout_real;
  lane_vec_t         dout_imag;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cbfp0_reorder_buf dut (
    .clk         (clk),
    .rst         (rst),
    .din_valid   (din_valid),
    .flush       (flush),
    .bfly02_real (in_re),
    .bfly02_imag (in_im),
    .valid_out   (valid_out),
    .frame_start (frame_start),
    .beat_idx    (beat_idx),
    .dout_real   (dout_real),
    .dout_imag   (dout_imag)
  );

  // One cycle: inputs applied before the edge, expected outputs after it.
  typedef struct {
    bit dv;
    bit fl;
    int b;
    int ib;
    bit ev;
    bit efs;
    int ek;
    int eb;
  } vec_t;

  vec_t tbl[$];

  function automatic lane_vec_t in_vec(int base, int b, bit neg);
    lane_vec_t v;
    for (int l = 0; l < int'(LANES); l++) begin
      int x;
      x = base + int'(LANES) * b + l;
      v[l] = neg ? DATA_WIDTH'(-x) : DATA_WIDTH'(x);
    end
    return v;
  endfunction

  function automatic lane_vec_t exp_vec(int base, int k, bit neg);
    lane_vec_t v;
    for (int l = 0; l < int'(LANES); l++) begin
      int x;
      x = base + int'(BEATS) * l + k;
      v[l] = neg ? DATA_WIDTH'(-x) : DATA_WIDTH'(x);
    end
    return v;
  endfunction

  function automatic lane_vec_t alt_vec(bit even_min);
    lane_vec_t v;
    for (int l = 0; l < int'(LANES); l++)
      v[l] = ((l % 2 == 0) == even_min) ? DATA_WIDTH'(-4096) : DATA_WIDTH'(4095);
    return v;
  endfunction

  function automatic lane_vec_t fill_vec(int s);
    lane_vec_t v;
    for (int l = 0; l < int'(LANES); l++) v[l] = DATA_WIDTH'(s);
    return v;
  endfunction

  task automatic add(bit dv, bit fl, int b, int ib, bit ev, bit efs, int ek, int eb);
    vec_t r;
    r.dv = dv; r.fl = fl; r.b = b; r.ib = ib;
    r.ev = ev; r.efs = efs; r.ek = ek; r.eb = eb;
    tbl.push_back(r);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    // single block, base 0
    for (int b = 0; b < 4; b++) add(1, 0, b, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) add(0, 0, 0, 0, 1, k == 0, k, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    // three back-to-back blocks, offsets 64*n
    for (int j = 0; j < 16; j++) begin
      bit ev;
      int k;
      ev = (j >= 4);
      k  = ev ? (j - 4) % 4 : 0;
      add(j < 12, 0, j % 4, 64 * (j / 4), ev, ev && k == 0, k, ev ? 64 * ((j - 4) / 4) : 0);
    end
    add(0, 0, 0, 0, 0, 0, 0, 0);
    // gapped input beats
    for (int j = 0; j < 7; j++) add(j % 2 == 0, 0, j / 2, 200, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) add(0, 0, 0, 0, 1, k == 0, k, 200);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    // partial block, flush (beat in flush cycle ignored), then clean block
    add(1, 0, 0, 500, 0, 0, 0, 0);
    add(1, 0, 1, 500, 0, 0, 0, 0);
    add(1, 1, 2, 500, 0, 0, 0, 0);
    for (int b = 0; b < 4; b++) add(1, 0, b, 100, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) add(0, 0, 0, 0, 1, k == 0, k, 100);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    // flush while a block is being read out
    for (int b = 0; b < 4; b++) add(1, 0, b, 20, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 20);
    add(0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);

    rst = 1'b1; din_valid = 1'b0; flush = 1'b0; in_re = '0; in_im = '0;
    #2;
    chk("reset_valid", 256'(valid_out), 256'(0));
    chk("reset_frame_start", 256'(frame_start), 256'(0));
    chk("reset_beat_idx", 256'(beat_idx), 256'(0));
    chk("reset_dout_real", 256'(dout_real), 256'(0));
    chk("reset_dout_imag", 256'(dout_imag), 256'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();

    foreach (tbl[i]) begin
      din_valid = tbl[i].dv;
      flush     = tbl[i].fl;
      in_re     = in_vec(tbl[i].ib, tbl[i].b, 1'b0);
      in_im     = in_vec(tbl[i].ib, tbl[i].b, 1'b1);
      step();
      chk($sformatf("row%0d_valid", i), 256'(valid_out), 256'(tbl[i].ev));
      chk($sformatf("row%0d_frame_start", i), 256'(frame_start), 256'(tbl[i].efs));
      chk($sformatf("row%0d_beat_idx", i), 256'(beat_idx),
          256'(tbl[i].ev ? tbl[i].ek : 0));
      if (tbl[i].ev) begin
        chk($sformatf("row%0d_dout_real", i), 256'(dout_real),
            256'(exp_vec(tbl[i].eb, tbl[i].ek, 1'b0)));
        chk($sformatf("row%0d_dout_imag", i), 256'(dout_imag),
            256'(exp_vec(tbl[i].eb, tbl[i].ek, 1'b1)));
      end
    end
    din_valid = 1'b0;
    flush     = 1'b0;

    // async reset during output beat 2
    for (int b = 0; b < 4; b++) begin
      din_valid = 1'b1;
      in_re = in_vec(40, b, 1'b0);
      in_im = in_vec(40, b, 1'b1);
      step();
    end
    din_valid = 1'b0;
    step(); step(); step();
    chk("pre_reset_valid", 256'(valid_out), 256'(1));
    chk("pre_reset_beat_idx", 256'(beat_idx), 256'(2));
    #2 rst = 1'b1;
    #1;
    chk("async_reset_valid", 256'(valid_out), 256'(0));
    chk("async_reset_dout_real", 256'(dout_real), 256'(0));
    chk("async_reset_dout_imag", 256'(dout_imag), 256'(0));
    chk("async_reset_beat_idx", 256'(beat_idx), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      chk($sformatf("post_reset_idle%0d", c), 256'(valid_out), 256'(0));
    end

    // full-scale alternating lanes
    for (int b = 0; b < 4; b++) begin
      din_valid = 1'b1;
      in_re = alt_vec(1'b1);
      in_im = alt_vec(1'b0);
      step();
    end
    din_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("fullscale_valid_k%0d", k), 256'(valid_out), 256'(1));
      chk($sformatf("fullscale_real_k%0d", k), 256'(dout_real),
          256'(fill_vec(k % 2 == 0 ? -4096 : 4095)));
      chk($sformatf("fullscale_imag_k%0d", k), 256'(dout_imag),
          256'(fill_vec(k % 2 == 0 ? 4095 : -4096)));
    end
    step();
    chk("fullscale_done", 256'(valid_out), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
